// File: rtl/regfile_stream_reader.sv
// Small in-order FIFO used as the output skid buffer of the stream reader.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: pops only when pop_rdy; the producer must not push while full.
module regfile_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_vld,
  input  logic [WIDTH-1:0]             push_dat,
  output logic                         pop_vld,
  output logic [WIDTH-1:0]             pop_dat,
  input  logic                         pop_rdy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  // Pointers wrap naturally, so DEPTH is expected to be a power of two.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign pop_vld = (count != '0);
  assign pop_dat = mem[rd_ptr];
  assign do_pop  = pop_vld & pop_rdy;
  assign do_push = push_vld;

  // Storage, pointers and occupancy; push and pop in the same cycle keep count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// Burst read initiator: streams `length` register-file words from base_addr.
// Latency: start sampled in cycle 0, rf read in cycle 1, first out_valid in cycle 3.
// Backpressure: reads are issued only while FIFO words plus in-flight reads stay below 4.
module regfile_stream_reader #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_DEPTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_DEPTH-1:0] base_addr,
  input  logic [ADDR_DEPTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_DEPTH-1:0] rf_address,
  output logic                  rf_en_read,
  output logic                  rf_en_write,
  input  logic [DATA_WIDTH-1:0] rf_data_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH+1);
  localparam int LEN_W      = ADDR_DEPTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;

  logic [ADDR_DEPTH-1:0] base_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      issued_q;

  // rf_last_q rides alongside rf_en_read; s1_* is the cycle in which RF data is valid.
  logic                  rf_last_q;
  logic                  s1_vld;
  logic                  s1_last;

  logic                  accept_burst;
  logic                  issue_now;
  logic                  issue_last;
  logic                  credit_ok;
  logic [CNT_W:0]        committed;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_vld;
  logic [DATA_WIDTH:0]   fifo_head;

  // Words already buffered plus reads still travelling through the RF pipeline.
  assign committed = {1'b0, fifo_count}
                   + (CNT_W+1)'(rf_en_read)
                   + (CNT_W+1)'(s1_vld);
  assign credit_ok = (committed < (CNT_W+1)'(FIFO_DEPTH));

  assign accept_burst = (state_q == IDLE) && start && (length != '0);

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign rf_en_write = 1'b0;

  // Next-state and issue decision; the first read is launched from IDLE so it
  // reaches the RF port in the cycle right after start.
  always_comb begin
    state_d    = state_q;
    issue_now  = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            issue_now  = 1'b1;
            issue_last = (length == LEN_W'(1));
            state_d    = READ;
          end else begin
            state_d    = DONE;
          end
        end
      end
      READ: begin
        if (issued_q == len_q) begin
          state_d = DRAIN;
        end else if (credit_ok) begin
          issue_now  = 1'b1;
          issue_last = ((issued_q + LEN_W'(1)) == len_q);
          if (issue_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!rf_en_read && !s1_vld && (fifo_count == '0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst parameters, issue counter and the registered RF request port.
  always_ff @(posedge clock) begin
    if (reset) begin
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      rf_address <= '0;
      rf_en_read <= 1'b0;
      rf_last_q  <= 1'b0;
    end else begin
      rf_en_read <= issue_now;
      rf_last_q  <= issue_last;
      if (accept_burst) begin
        base_q     <= base_addr;
        len_q      <= length;
        rf_address <= base_addr;
        issued_q   <= LEN_W'(1);
      end else if (issue_now) begin
        // Address arithmetic is modulo the RF size, so bursts wrap past the top.
        rf_address <= base_q + issued_q[ADDR_DEPTH-1:0];
        issued_q   <= issued_q + LEN_W'(1);
      end
    end
  end

  // Delay the issue strobe once more to mark the cycle in which rf_data_in is driven.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      s1_vld  <= rf_en_read;
      s1_last <= rf_last_q;
    end
  end

  regfile_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (s1_vld),
    .push_dat ({s1_last, rf_data_in}),
    .pop_vld  (fifo_vld),
    .pop_dat  (fifo_head),
    .pop_rdy  (out_ready),
    .count    (fifo_count)
  );

  assign out_valid = fifo_vld;
  assign out_data  = fifo_head[DATA_WIDTH-1:0];
  assign out_last  = fifo_vld & fifo_head[DATA_WIDTH];

endmodule

// File: doc/regfile_stream_reader.md
Name: regfile_stream_reader

Overview:
- Read initiator for the 24-bit synchronous register file used by the cat-recognizer datapath.
- On a start pulse, issues a burst of `length` sequential reads from `base_addr` over the register-file port.
- Captures each returned word with correct latency and delivers it on a valid/ready stream to the downstream compute stage (e.g. the dot-product/MAC unit).
- Internal 4-entry FIFO absorbs backpressure; no word is lost or duplicated.

Parameters:
- DATA_WIDTH, 24, register-file word width.
- ADDR_DEPTH, 12, register-file address width (2^ADDR_DEPTH words).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle burst request; sampled only when busy=0.
- base_addr  in  ADDR_DEPTH  first address of the burst; latched on accepted start.
- length  in  ADDR_DEPTH+1  word count, 0..2^ADDR_DEPTH; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the burst has fully drained.
- rf_address  out  ADDR_DEPTH  register-file address (registered).
- rf_en_read  out  1  register-file read enable (registered).
- rf_en_write  out  1  constant 0; this block never writes.
- rf_data_in  in  DATA_WIDTH  register-file data_out; valid only the cycle after the RF samples en_read, Z otherwise.
- out_data  out  DATA_WIDTH  stream word (FIFO head).
- out_valid  out  1  stream valid.
- out_last  out  1  high with the final word of the burst.
- out_ready  in  1  downstream accept; a transfer occurs when out_valid and out_ready are both high.

Behaviour:
- Reset values: busy=0, done=0, rf_en_read=0, rf_address=0, rf_en_write=0, out_valid=0, out_last=0, out_data=0. FIFO flushed, in-flight tracking cleared, FSM=IDLE.
- Reset mid-burst aborts immediately: no further captures, no done pulse.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 and length>0 → latch base/length, issued=0, go to READ. start=1 and length=0 → go to DONE (no reads). Otherwise stay.
  - READ: issue one read per cycle when issued<length and fifo_count+inflight<4. Issuing means rf_en_read=1 and rf_address=base+issued (mod 2^ADDR_DEPTH, wraps FFF→000), then issued++. After the last issue, go to DRAIN.
  - DRAIN: wait until inflight=0 and FIFO is empty (last word handshaked), then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=1 in this cycle, then go to IDLE.
- rf_en_read is 0 in every cycle with no issue, so the RF drives Z.
- Read pipeline: request presented in cycle N, RF samples at end of N, rf_data_in valid during N+1, block captures at end of N+1 into the FIFO, out_valid can rise in N+2.
  - inflight counts requests in cycles N and N+1 (0..2).
  - Capture is gated solely by a 2-stage delayed copy of the issue strobe. rf_data_in is never sampled otherwise (Z must never enter the FIFO).
- Latency: start sampled at end of cycle 0 → rf_en_read=1 in cycle 1 → first out_valid in cycle 3.
- Throughput: 1 word/cycle sustained with out_ready=1.
- FIFO: 4 entries, in-order. Simultaneous push and pop is allowed at any occupancy, count unchanged. Credit rule guarantees no overflow. Pop only on handshake.
- out_last is tagged at issue time on the word with issued==length-1 and travels with it.
- start while busy=1 is ignored (no re-latch, no effect).
- length=2^ADDR_DEPTH reads every word once, base first, wrapping.
- out_data holds its value while out_valid=1 and out_ready=0.

Test Plan:
1. RF preloaded with word[a]=0x100000+a; base=0x010, length=4, out_ready=1 → out_data 0x100010..0x100013 on 4 consecutive cycles starting cycle 3; out_last only on 0x100013; one done pulse; busy=0 afterwards.
2. base=0x020, length=8, out_ready pattern 1,0,0,1,0,1,1,0 repeating → 0x100020..0x100027 in order, no loss or duplication; rf_en_read=0 whenever fifo_count+inflight=4; FIFO never exceeds 4.
3. base=0xFFE, length=4 → rf_address sequence FFE, FFF, 000, 001; data 0x100FFE, 0x100FFF, 0x100000, 0x100001.
4. start with length=0 → done=1 in cycle 1 only; rf_en_read, out_valid and out_last stay 0 throughout.
5. length=16 with reset asserted after 3 handshakes → next cycle all outputs at reset values, no done pulse; a subsequent start with base=0x000, length=2 returns 0x100000, 0x100001 cleanly.
6. Second start pulsed mid-burst with different base/length → ignored; original burst completes unchanged; then length=4096, base=0x800 → 4096 words, wrap at 0xFFF, out_last on word[0x7FF].
